// File: rtl/usr_pkg.sv
// Shared types and defaults for the universal shift register.
package usr_pkg;

    typedef enum logic [1:0] {
        USR_HOLD = 2'b00,
        USR_SHR  = 2'b01,
        USR_SHL  = 2'b10,
        USR_LOAD = 2'b11
    } usr_mode_t;

    localparam int unsigned USR_DEFAULT_WIDTH = 4;

endpackage : usr_pkg

// File: rtl/usr_bit_cell.sv
// One register bit: 4:1 mode mux (hold / right shift / left shift / load) feeding a flop with synchronous active-low clear.
module usr_bit_cell
    import usr_pkg::*;
(
    input  logic      clc,
    input  logic      clear,
    input  usr_mode_t mode,
    input  logic      shr_src,
    input  logic      shl_src,
    input  logic      par_bit,
    output logic      q
);

    logic d;

    // Unknown or hold mode keeps the current value
    always_comb begin
        d = q;
        case (mode)
            USR_HOLD: d = q;
            USR_SHR:  d = shr_src;
            USR_SHL:  d = shl_src;
            USR_LOAD: d = par_bit;
            default:  d = q;
        endcase
    end

    always_ff @(posedge clc) begin
        if (!clear) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule : usr_bit_cell

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right, shift left or parallel load per cycle.
// Optional USR_ROTATE_EN adds a rotate input that closes the shift path end-to-end.
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = USR_DEFAULT_WIDTH
) (
    input  logic             clc,
    input  logic             clear,
    input  logic             left_in,
    input  logic             right_in,
    input  logic [WIDTH-1:0] par_in,
    input  logic [1:0]       sel,
`ifdef USR_ROTATE_EN
    input  logic             rotate,
`endif
    output logic [WIDTH-1:0] out
);

    localparam int MSB = int'(WIDTH) - 1;

    usr_mode_t        mode;
    logic [WIDTH-1:0] q;
    logic             shr_msb;
    logic             shl_lsb;

    assign mode = usr_mode_t'(sel);

    // Boundary sources: serial inputs, or the opposite end when rotating
`ifdef USR_ROTATE_EN
    assign shr_msb = rotate ? q[0]   : right_in;
    assign shl_lsb = rotate ? q[MSB] : left_in;
`else
    assign shr_msb = right_in;
    assign shl_lsb = left_in;
`endif

    for (genvar i = 0; i <= MSB; i++) begin : g_bit
        logic shr_src;
        logic shl_src;

        if (i == MSB) begin : g_msb
            assign shr_src = shr_msb;
        end else begin : g_mid_r
            assign shr_src = q[i+1];
        end

        if (i == 0) begin : g_lsb
            assign shl_src = shl_lsb;
        end else begin : g_mid_l
            assign shl_src = q[i-1];
        end

        usr_bit_cell u_cell (
            .clc     (clc),
            .clear   (clear),
            .mode    (mode),
            .shr_src (shr_src),
            .shl_src (shl_src),
            .par_bit (par_in[i]),
            .q       (q[i])
        );
    end

    assign out = q;

endmodule : univ_shift_reg

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg (WIDTH=4); driver queues expectations, monitor checks after each edge.
module tb_univ_shift_reg;

    localparam int unsigned W = 4;

    typedef struct {
        string      name;
        logic [3:0] value;
    } exp_t;

    logic         clc;
    logic         clear;
    logic         left_in;
    logic         right_in;
    logic [W-1:0] par_in;
    logic [1:0]   sel;
    logic         rotate;
    logic [W-1:0] out;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    univ_shift_reg #(.WIDTH(W)) dut (
        .clc      (clc),
        .clear    (clear),
        .left_in  (left_in),
        .right_in (right_in),
        .par_in   (par_in),
        .sel      (sel),
`ifdef USR_ROTATE_EN
        .rotate   (rotate),
`endif
        .out      (out)
    );

    initial clc = 1'b0;
    always #5 clc = ~clc;

    // Monitor: every rising edge produces one register value; pop and compare
    initial begin
        forever begin
            @(posedge clc);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (out !== e.value) begin
                    errors++;
                    $display("FAIL %s: got %b expected %b", e.name, out, e.value);
                end
            end
        end
    end

    // Drive one edge worth of inputs and queue the value expected after it
    task automatic step(input logic clr, input logic [1:0] s, input logic li, input logic ri,
                        input logic [3:0] p, input logic rot, input logic [3:0] ev, input string nm);
        exp_t e;
        @(negedge clc);
        clear    = clr;
        sel      = s;
        left_in  = li;
        right_in = ri;
        par_in   = p;
        rotate   = rot;
        e.name   = nm;
        e.value  = ev;
        exp_q.push_back(e);
    endtask

    initial begin
        clear = 1'b1; sel = 2'b00; left_in = 1'b0; right_in = 1'b0; par_in = '0; rotate = 1'b0;

        // 1: preload F, then clear beats load
        step(1, 2'b11, 0, 0, 4'hF, 0, 4'b1111, "preload");
        step(0, 2'b11, 1, 1, 4'h5, 0, 4'b0000, "reset_wins");

        // 2: shift right with right_in=1, then 0; left_in and par_in are ignored
        step(1, 2'b01, 0, 1, 4'hF, 0, 4'b1000, "shr1");
        step(1, 2'b01, 1, 1, 4'h0, 0, 4'b1100, "shr2");
        step(1, 2'b01, 0, 1, 4'hA, 0, 4'b1110, "shr3");
        step(1, 2'b01, 1, 1, 4'h5, 0, 4'b1111, "shr4");
        step(1, 2'b01, 1, 0, 4'hF, 0, 4'b0111, "shr5");

        // 3: load 1010, shift left
        step(1, 2'b11, 1, 1, 4'hA, 0, 4'b1010, "load_a");
        step(1, 2'b10, 0, 1, 4'hF, 0, 4'b0100, "shl1");
        step(1, 2'b10, 0, 1, 4'hF, 0, 4'b1000, "shl2");
        step(1, 2'b10, 1, 0, 4'h0, 0, 4'b0001, "shl3");

        // 4: load then hold with toggling unused inputs
        step(1, 2'b11, 0, 0, 4'hA, 0, 4'b1010, "load_hold");
        step(1, 2'b00, 1, 0, 4'h5, 0, 4'b1010, "hold1");
        step(1, 2'b00, 0, 1, 4'h5, 0, 4'b1010, "hold2");
        step(1, 2'b00, 1, 1, 4'h5, 0, 4'b1010, "hold3");

        // 5: reset in the middle of a right shift
        step(0, 2'b01, 0, 1, 4'h0, 0, 4'b0000, "mid_pre_rst");
        step(1, 2'b01, 0, 1, 4'h0, 0, 4'b1000, "mid_shr1");
        step(1, 2'b01, 0, 1, 4'h0, 0, 4'b1100, "mid_shr2");
        step(0, 2'b01, 0, 1, 4'h0, 0, 4'b0000, "mid_rst");
        step(1, 2'b01, 0, 1, 4'h0, 0, 4'b1000, "mid_resume");

        // Boundary: MSB falls out on shift left, LSB falls out on shift right
        step(1, 2'b10, 0, 1, 4'h0, 0, 4'b0000, "shl_drop_msb");
        step(1, 2'b11, 0, 0, 4'h1, 0, 4'b0001, "load_1");
        step(1, 2'b01, 1, 0, 4'h0, 0, 4'b0000, "shr_drop_lsb");

`ifdef USR_ROTATE_EN
        // 6: rotate closes the loop; serial inputs ignored
        step(1, 2'b11, 0, 0, 4'h9, 1, 4'b1001, "rot_load");
        step(1, 2'b01, 1, 0, 4'h0, 1, 4'b1100, "rotr1");
        step(1, 2'b01, 1, 1, 4'hF, 1, 4'b0110, "rotr2");
        step(1, 2'b10, 1, 1, 4'h0, 1, 4'b1100, "rotl1");
        step(1, 2'b00, 1, 1, 4'h0, 1, 4'b1100, "rot_hold");
        step(0, 2'b10, 1, 1, 4'h0, 1, 4'b0000, "rot_reset");
`endif

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clc);
        #2;
        if (exp_q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_univ_shift_reg
